// File: rtl/mul_issue_pkg.sv
// Shared GF(2^233) field definitions and the issue FSM state encoding.
package mul_issue_pkg;

    // Field degree: elements are polynomials over GF(2) of degree < GF_N
    localparam int GF_N = 233;

    // Middle tap of the trinomial reduction polynomial x^233 + x^74 + 1
    localparam int POLY_K = 74;

    // x^233 folded back into the field: x^233 == x^74 + 1
    localparam logic [GF_N-1:0] POLY_RED =
        {{(GF_N-POLY_K-1){1'b0}}, 1'b1, {(POLY_K-1){1'b0}}, 1'b1};

    // Issue controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mul_issue.sv
// Request/response wrapper around an external field multiplier.
// Accepts one operand pair at a time, starts the multiplier, waits for the
// result with a per-attempt timeout, re-issues on timeout up to MAX_RETRY
// times and finally reports either the product or a failure.
module mul_issue
    import mul_issue_pkg::*;
#(
    parameter int          n         = GF_N,
    parameter logic [15:0] TIMEOUT   = 16'd1023,
    parameter int          MAX_RETRY = 2
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         REQ_VALID,
    output logic         REQ_READY,
    input  logic [n-1:0] REQ_A,
    input  logic [n-1:0] REQ_B,
    input  logic [3:0]   REQ_TAG,
    output logic         MUL_IN_VALID,
    output logic [n-1:0] MUL_A,
    output logic [n-1:0] MUL_B,
    input  logic [n-1:0] MUL_DOUT,
    input  logic         MUL_OUT_VALID,
    input  logic         MUL_ERROR,
    output logic         RSP_VALID,
    input  logic         RSP_READY,
    output logic [n-1:0] RSP_C,
    output logic [3:0]   RSP_TAG,
    output logic         RSP_FAIL,
    output logic [7:0]   ERR_CNT
);

    state_t       r_state;
    logic         r_mulInValid;
    logic [n-1:0] r_mulA;
    logic [n-1:0] r_mulB;
    logic [3:0]   r_tag;
    logic [15:0]  r_waitCnt;
    logic [7:0]   r_retryCnt;
    logic         r_rspValid;
    logic [n-1:0] r_rspC;
    logic         r_rspFail;
    logic [7:0]   r_errCnt;

    logic [15:0]  w_waitNext;
    logic         w_timeout;
    logic         w_retryLeft;

    // The wait counter saturates so a very long attempt can never wrap
    assign w_waitNext  = (r_waitCnt == 16'hFFFF) ? r_waitCnt : r_waitCnt + 16'd1;
    // Timeout fires in the WAIT cycle whose incremented count reaches TIMEOUT
    assign w_timeout   = (w_waitNext >= TIMEOUT);
    assign w_retryLeft = (r_retryCnt < 8'(MAX_RETRY));

    assign REQ_READY     = (r_state == ST_IDLE);
    assign MUL_IN_VALID  = r_mulInValid;
    assign MUL_A         = r_mulA;
    assign MUL_B         = r_mulB;
    assign RSP_VALID     = r_rspValid;
    assign RSP_C         = r_rspC;
    assign RSP_TAG       = r_tag;
    assign RSP_FAIL      = r_rspFail;
    assign ERR_CNT       = r_errCnt;

    // Issue FSM; the start pulse is raised on entry to ISSUE so it is high exactly in ISSUE
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= ST_IDLE;
            r_mulInValid <= 1'b0;
            r_mulA       <= '0;
            r_mulB       <= '0;
            r_tag        <= 4'd0;
            r_waitCnt    <= 16'd0;
            r_retryCnt   <= 8'd0;
            r_rspValid   <= 1'b0;
            r_rspC       <= '0;
            r_rspFail    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        r_mulA       <= REQ_A;
                        r_mulB       <= REQ_B;
                        r_tag        <= REQ_TAG;
                        r_retryCnt   <= 8'd0;
                        r_mulInValid <= 1'b1;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_mulInValid <= 1'b0;
                    r_waitCnt    <= 16'd0;
                    r_state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_waitCnt <= w_waitNext;
                    if (MUL_OUT_VALID) begin
                        r_rspC     <= MUL_DOUT;
                        r_rspFail  <= 1'b0;
                        r_rspValid <= 1'b1;
                        r_state    <= ST_RESP;
                    end else if (w_timeout) begin
                        if (w_retryLeft) begin
                            r_retryCnt   <= r_retryCnt + 8'd1;
                            r_mulInValid <= 1'b1;
                            r_state      <= ST_ISSUE;
                        end else begin
                            r_rspC     <= '0;
                            r_rspFail  <= 1'b1;
                            r_rspValid <= 1'b1;
                            r_state    <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (RSP_READY) begin
                        r_rspValid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_mulInValid <= 1'b0;
                    r_rspValid   <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating count of parity errors reported while a result is awaited
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_errCnt <= 8'd0;
        end else if (MUL_ERROR && (r_state == ST_WAIT) && (r_errCnt != 8'hFF)) begin
            r_errCnt <= r_errCnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_mul_issue.sv
// Directed bench for mul_issue with a behavioural GF(2^233) multiplier beside it.
module tb_mul_issue;
    import mul_issue_pkg::*;

    localparam int MUL_LAT = 6;

    logic            clk;
    logic            rstN;
    logic            reqValid;
    logic            reqReady;
    logic [GF_N-1:0] reqA;
    logic [GF_N-1:0] reqB;
    logic [3:0]      reqTag;
    logic            mulInValid;
    logic [GF_N-1:0] mulA;
    logic [GF_N-1:0] mulB;
    logic [GF_N-1:0] mulDout = '0;
    logic            mulOutValid = 1'b0;
    logic            mulError;
    logic            rspValid;
    logic            rspReady;
    logic [GF_N-1:0] rspC;
    logic [3:0]      rspTag;
    logic            rspFail;
    logic [7:0]      errCnt;

    int assertCount = 0;
    int failCount   = 0;
    int cycleNo     = 0;
    int pulseCount  = 0;
    int pulseCycle [64];
    int rspCycle    = 0;

    logic            mulSilent = 1'b0;
    logic            mulBusy   = 1'b0;
    int              mulCnt    = 0;

    mul_issue #(
        .n         (GF_N),
        .TIMEOUT   (16'd20),
        .MAX_RETRY (2)
    ) dut (
        .CLK           (clk),
        .RST_N         (rstN),
        .REQ_VALID     (reqValid),
        .REQ_READY     (reqReady),
        .REQ_A         (reqA),
        .REQ_B         (reqB),
        .REQ_TAG       (reqTag),
        .MUL_IN_VALID  (mulInValid),
        .MUL_A         (mulA),
        .MUL_B         (mulB),
        .MUL_DOUT      (mulDout),
        .MUL_OUT_VALID (mulOutValid),
        .MUL_ERROR     (mulError),
        .RSP_VALID     (rspValid),
        .RSP_READY     (rspReady),
        .RSP_C         (rspC),
        .RSP_TAG       (rspTag),
        .RSP_FAIL      (rspFail),
        .ERR_CNT       (errCnt)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MSB-first shift-and-add multiply with reduction by x^233 = x^74 + 1
    function automatic logic [GF_N-1:0] gfMul(input logic [GF_N-1:0] a, input logic [GF_N-1:0] b);
        logic [GF_N-1:0] p;
        logic            carry;
        p = '0;
        for (int i = GF_N - 1; i >= 0; i--) begin
            carry = p[GF_N-1];
            p = p << 1;
            if (carry) p = p ^ POLY_RED;
            if (b[i]) p = p ^ a;
        end
        return p;
    endfunction

    // Multiplier model: restarts on every start pulse, answers MUL_LAT edges later unless silenced
    always @(posedge clk) begin
        mulOutValid <= 1'b0;
        if (mulInValid) begin
            mulBusy <= 1'b1;
            mulCnt  <= MUL_LAT - 1;
            mulDout <= gfMul(mulA, mulB);
        end else if (mulBusy) begin
            if (mulCnt == 0) begin
                mulBusy     <= 1'b0;
                mulOutValid <= !mulSilent;
            end else begin
                mulCnt <= mulCnt - 1;
            end
        end
    end

    // Cycle counter and record of the cycle index of every start pulse
    always @(posedge clk) begin
        cycleNo <= cycleNo + 1;
        if (mulInValid) begin
            if (pulseCount < 64) pulseCycle[pulseCount] <= cycleNo;
            pulseCount <= pulseCount + 1;
        end
    end

    // Hard stop in case some wait is never satisfied
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [255:0] obs, input logic [255:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", name, obs, exp);
        end
    endtask

    // Present one request and hold it until the block takes it
    task automatic applyStimulus(input logic [GF_N-1:0] a, input logic [GF_N-1:0] b, input logic [3:0] tag);
        logic accepted;
        accepted = 1'b0;
        reqA     = a;
        reqB     = b;
        reqTag   = tag;
        reqValid = 1'b1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            if (reqReady) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        reqValid = 1'b0;
        checkOutput("req_accepted", 256'(accepted), 256'd1);
    endtask

    // Wait a bounded number of cycles for RSP_VALID and note the cycle it appeared
    task automatic waitRsp(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            if (rspValid) begin
                seen     = 1'b1;
                rspCycle = cycleNo;
            end
        end
        checkOutput("rsp_arrived", 256'(seen), 256'd1);
    endtask

    task automatic finishRsp();
        rspReady = 1'b1;
        @(posedge clk);
        #1;
        rspReady = 1'b0;
        checkOutput("rsp_dropped", 256'(rspValid), 256'd0);
        checkOutput("ready_after_rsp", 256'(reqReady), 256'd1);
    endtask

    initial begin
        logic [GF_N-1:0] a;
        logic [GF_N-1:0] b;
        logic [GF_N-1:0] expC;
        int              p0;
        logic            sawRsp;

        rstN     = 1'b0;
        reqValid = 1'b0;
        reqA     = '0;
        reqB     = '0;
        reqTag   = 4'd0;
        mulError = 1'b0;
        rspReady = 1'b0;

        // Reset values
        #1;
        checkOutput("rst_req_ready", 256'(reqReady), 256'd1);
        checkOutput("rst_mul_in_valid", 256'(mulInValid), 256'd0);
        checkOutput("rst_rsp_valid", 256'(rspValid), 256'd0);
        checkOutput("rst_rsp_fail", 256'(rspFail), 256'd0);
        checkOutput("rst_err_cnt", 256'(errCnt), 256'd0);
        checkOutput("rst_rsp_c", 256'(rspC), 256'd0);
        checkOutput("rst_rsp_tag", 256'(rspTag), 256'd0);
        checkOutput("rst_mul_a", 256'(mulA), 256'd0);
        checkOutput("rst_mul_b", 256'(mulB), 256'd0);
        repeat (3) @(posedge clk);
        #1;
        rstN = 1'b1;
        @(posedge clk);
        #1;

        // 1 * 1 = 1 with a single start pulse
        $display("[TB] test: 1 * 1");
        a = '0; a[0] = 1'b1;
        b = '0; b[0] = 1'b1;
        p0 = pulseCount;
        applyStimulus(a, b, 4'd3);
        waitRsp(40);
        expC = '0; expC[0] = 1'b1;
        checkOutput("one_rsp_c", 256'(rspC), 256'(expC));
        checkOutput("one_rsp_tag", 256'(rspTag), 256'd3);
        checkOutput("one_rsp_fail", 256'(rspFail), 256'd0);
        checkOutput("one_pulse_count", 256'(pulseCount - p0), 256'd1);
        checkOutput("one_req_ready_busy", 256'(reqReady), 256'd0);
        finishRsp();

        // x^232 * x = x^233 = x^74 + 1
        $display("[TB] test: x^232 * x");
        a = '0; a[232] = 1'b1;
        b = '0; b[1] = 1'b1;
        applyStimulus(a, b, 4'd5);
        waitRsp(40);
        expC = '0; expC[74] = 1'b1; expC[0] = 1'b1;
        checkOutput("wrap_rsp_c", 256'(rspC), 256'(expC));
        checkOutput("wrap_rsp_tag", 256'(rspTag), 256'd5);
        finishRsp();

        // (x^231 + 1) * x^2 = x^74 + x^2 + 1, then back-pressure for 10 cycles
        $display("[TB] test: response held under back-pressure");
        a = '0; a[231] = 1'b1; a[0] = 1'b1;
        b = '0; b[2] = 1'b1;
        applyStimulus(a, b, 4'd9);
        waitRsp(40);
        expC = '0; expC[74] = 1'b1; expC[2] = 1'b1; expC[0] = 1'b1;
        checkOutput("hold_rsp_c_first", 256'(rspC), 256'(expC));
        reqA     = '1;
        reqB     = '1;
        reqTag   = 4'd15;
        reqValid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_rsp_valid", 256'(rspValid), 256'd1);
            checkOutput("hold_rsp_c", 256'(rspC), 256'(expC));
            checkOutput("hold_rsp_tag", 256'(rspTag), 256'd9);
            checkOutput("hold_req_ready", 256'(reqReady), 256'd0);
            checkOutput("hold_mul_a", 256'(mulA), 256'(a));
        end
        reqValid = 1'b0;
        finishRsp();

        // Parity errors: 3 cycles in WAIT count, 2 cycles in IDLE do not
        $display("[TB] test: error counter");
        a = '0; a[1] = 1'b1;
        b = '0; b[1] = 1'b1;
        applyStimulus(a, b, 4'd6);
        @(posedge clk);
        #1;
        mulError = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mulError = 1'b0;
        checkOutput("err_cnt_wait", 256'(errCnt), 256'd3);
        waitRsp(40);
        expC = '0; expC[2] = 1'b1;
        checkOutput("err_rsp_c", 256'(rspC), 256'(expC));
        finishRsp();
        mulError = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mulError = 1'b0;
        checkOutput("err_cnt_idle", 256'(errCnt), 256'd3);

        // Silent multiplier: three attempts 21 cycles apart, then a failure response
        $display("[TB] test: timeout and retries");
        mulSilent = 1'b1;
        p0 = pulseCount;
        a = '0; a[7] = 1'b1;
        b = '0; b[9] = 1'b1;
        applyStimulus(a, b, 4'd11);
        waitRsp(120);
        checkOutput("to_pulse_count", 256'(pulseCount - p0), 256'd3);
        if (p0 + 2 < 64) begin
            checkOutput("to_gap_1", 256'(pulseCycle[p0+1] - pulseCycle[p0]), 256'd21);
            checkOutput("to_gap_2", 256'(pulseCycle[p0+2] - pulseCycle[p0+1]), 256'd21);
            checkOutput("to_rsp_delay", 256'(rspCycle - pulseCycle[p0+2]), 256'd21);
        end
        checkOutput("to_rsp_valid", 256'(rspValid), 256'd1);
        checkOutput("to_rsp_fail", 256'(rspFail), 256'd1);
        checkOutput("to_rsp_c", 256'(rspC), 256'd0);
        checkOutput("to_rsp_tag", 256'(rspTag), 256'd11);
        finishRsp();
        mulSilent = 1'b0;

        // Reset mid-WAIT abandons the request; the late multiplier pulse is ignored
        $display("[TB] test: reset during WAIT");
        a = '0; a[3] = 1'b1;
        b = '0; b[4] = 1'b1;
        applyStimulus(a, b, 4'd7);
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("mid_rst_rsp_valid", 256'(rspValid), 256'd0);
        checkOutput("mid_rst_mul_in_valid", 256'(mulInValid), 256'd0);
        checkOutput("mid_rst_req_ready", 256'(reqReady), 256'd1);
        checkOutput("mid_rst_mul_a", 256'(mulA), 256'd0);
        checkOutput("mid_rst_mul_b", 256'(mulB), 256'd0);
        checkOutput("mid_rst_rsp_c", 256'(rspC), 256'd0);
        checkOutput("mid_rst_rsp_tag", 256'(rspTag), 256'd0);
        checkOutput("mid_rst_rsp_fail", 256'(rspFail), 256'd0);
        checkOutput("mid_rst_err_cnt", 256'(errCnt), 256'd0);
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        sawRsp = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (rspValid) sawRsp = 1'b1;
        end
        checkOutput("no_rsp_after_reset", 256'(sawRsp), 256'd0);
        checkOutput("idle_after_reset", 256'(reqReady), 256'd1);

        // x^2 * x^3 = x^5 completes normally after the reset
        a = '0; a[2] = 1'b1;
        b = '0; b[3] = 1'b1;
        applyStimulus(a, b, 4'd12);
        waitRsp(40);
        expC = '0; expC[5] = 1'b1;
        checkOutput("post_rst_rsp_c", 256'(rspC), 256'(expC));
        checkOutput("post_rst_rsp_tag", 256'(rspTag), 256'd12);
        checkOutput("post_rst_rsp_fail", 256'(rspFail), 256'd0);
        finishRsp();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mul_issue.md
MUL_ISSUE -- requirements
Module: mul_issue

Interface
REQ-001 SHALL have parameters: n, default 233, field width; TIMEOUT, default 16'd1023, cycles to wait for a result per attempt; MAX_RETRY, default 2, re-issues allowed after a timeout.
REQ-002 SHALL have ports, one per line:
CLK  input  1  single clock, rising edge;
RST_N  input  1  asynchronous active-low reset;
REQ_VALID  input  1  upstream operand pair valid;
REQ_READY  output  1  block can accept a request;
REQ_A  input  n  operand A;
REQ_B  input  n  operand B;
REQ_TAG  input  4  request identifier;
MUL_IN_VALID  output  1  start pulse to the field multiplier;
MUL_A  output  n  operand A to the multiplier;
MUL_B  output  n  operand B to the multiplier;
MUL_DOUT  input  n  multiplier result;
MUL_OUT_VALID  input  1  multiplier result valid, one-cycle pulse;
MUL_ERROR  input  1  multiplier parity-error flag;
RSP_VALID  output  1  response valid;
RSP_READY  input  1  downstream accepts the response;
RSP_C  output  n  product;
RSP_TAG  output  4  tag of the product;
RSP_FAIL  output  1  retries exhausted, RSP_C invalid;
ERR_CNT  output  8  saturating count of MUL_ERROR cycles.
REQ-003 Outputs SHALL be driven directly from registers, except REQ_READY, which is decoded from the state.

Function
REQ-004 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP.
REQ-005 IDLE: REQ_READY=1; when REQ_VALID=1, latch REQ_A into MUL_A, REQ_B into MUL_B and REQ_TAG into the tag register, clear the retry count, then go to ISSUE.
REQ-006 ISSUE: assert MUL_IN_VALID for exactly one cycle, clear the wait counter, then go to WAIT.
REQ-007 MUL_IN_VALID SHALL never be high in any state other than ISSUE, because the multiplier restarts on any start pulse.
REQ-008 MUL_A and MUL_B SHALL stay constant from the latch in IDLE until the block returns to IDLE.
REQ-009 WAIT: the wait counter increments once per cycle.
REQ-010 WAIT: when MUL_OUT_VALID=1, capture MUL_DOUT into RSP_C, set RSP_FAIL=0, then go to RESP.
REQ-011 WAIT: when the counter equals TIMEOUT and MUL_OUT_VALID=0, with retry count < MAX_RETRY, increment the retry count and go to ISSUE.
REQ-012 WAIT: when the counter equals TIMEOUT and MUL_OUT_VALID=0, with retry count = MAX_RETRY, set RSP_C=0 and RSP_FAIL=1, then go to RESP.
REQ-013 When MUL_OUT_VALID and the timeout occur in the same cycle, the result SHALL win.
REQ-014 A MUL_OUT_VALID pulse outside WAIT SHALL be ignored.
REQ-015 RESP: RSP_VALID=1, and RSP_C, RSP_TAG and RSP_FAIL held stable; when RSP_READY=1, clear RSP_VALID next cycle and go to IDLE.
REQ-016 REQ_READY SHALL be 0 in ISSUE, WAIT and RESP, so at most one request is in flight.
REQ-017 ERR_CNT SHALL increment in every cycle where MUL_ERROR=1 and state=WAIT, saturate at 8'hFF, and never clear except by reset.
REQ-018 Nominal latency from REQ_VALID acceptance to RSP_VALID SHALL be the multiplier latency + 3 cycles.
REQ-019 The wait counter SHALL be 16 bits and SHALL not wrap within one attempt.

Reset
REQ-020 RST_N low SHALL asynchronously force: state=IDLE, MUL_IN_VALID=0, RSP_VALID=0, RSP_FAIL=0, ERR_CNT=0, RSP_C=0, RSP_TAG=0, MUL_A=0, MUL_B=0, and wait and retry counters to 0.
REQ-021 Reset in any state SHALL abandon the request in flight, with no response emitted.

Structure
REQ-022 The shared field package SHALL hold n, the reduction polynomial taps (x^233+x^74+1) and the FSM state encodings.
REQ-023 The block SHALL contain no sub-module; the multiplier is instantiated beside it in the parent, port-to-port.

Verification
REQ-024 The bench SHALL cover A=1, B=1, TAG=3, with a real multiplier -> RSP_C=1, RSP_TAG=3, RSP_FAIL=0, and exactly one MUL_IN_VALID pulse.
REQ-025 The bench SHALL cover A=x^232 (bit 232 set), B=x (bit 1) -> RSP_C with only bits 74 and 0 set.
REQ-026 The bench SHALL cover a multiplier model that never pulses MUL_OUT_VALID, TIMEOUT=20 -> exactly 3 MUL_IN_VALID pulses 21 cycles apart, then RSP_VALID=1, RSP_FAIL=1, RSP_C=0.
REQ-027 The bench SHALL cover RSP_READY held low for 10 cycles after RSP_VALID -> RSP_VALID, RSP_C and RSP_TAG stable, REQ_READY=0 throughout, and a new REQ_VALID not accepted.
REQ-028 The bench SHALL cover MUL_ERROR high for 3 cycles in WAIT plus 2 cycles in IDLE -> ERR_CNT=3.
REQ-029 The bench SHALL cover RST_N pulsed low mid-WAIT -> all outputs at reset values immediately, no RSP_VALID afterwards, and a following request completes normally.
